arb_mux_n: RTL and testbench

//  - Parametrised N:1 data multiplexer with arbitration and a registered valid/ready output stage.
//  - Successor to the fixed 4:1 combinational select mux. Adds a configurable channel count and width,
//    per-channel handshakes, an internal grant in place of an external select, and one cycle of buffering.
//  - Merges requesters such as fetch, load/store and DMA onto one shared bus port of the RV core.

---
 rtl/arb_mux_pkg.sv | 24 ++
 rtl/arb_mux_n_rr_arbiter.sv | 30 +++
 rtl/arb_mux_n.sv | 93 +++++++++
 tb/tb_arb_mux_n.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arb_mux_n arbitrated multiplexer.
// Arbitration mode is selected by the ARB_MUX_RR_EN macro in the top level.
package arb_mux_pkg;

  // Round-robin pointer value after reset
  localparam int ARB_PTR_RST  = 0;

  // Widest channel count the index helper supports
  localparam int ARB_MAX_N    = 64;
  localparam int ARB_MAX_SELW = 6;

  // Converts a one-hot vector to its bit index.
  // OR-ing the indices of all set bits is exact for one-hot input and keeps the logic shallow.
  // An all-zero vector returns index 0.
  function automatic logic [ARB_MAX_SELW-1:0] onehot_to_idx(input logic [ARB_MAX_N-1:0] oh);
    logic [ARB_MAX_SELW-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      if (oh[i]) idx = idx | ARB_MAX_SELW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_mux_n_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo N. Used by arb_mux_n only when ARB_MUX_RR_EN is defined.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant
);

  logic found;
  int   j;

  // Search from ptr upwards and take the first active request
  always_comb begin
    grant = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// arb_mux_n: N:1 arbitrated multiplexer with a single registered valid/ready output stage.
// Build option: define ARB_MUX_RR_EN for round-robin arbitration; otherwise the lowest
// valid index always wins and no pointer register exists.
module arb_mux_n
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel
);

  logic [N-1:0]     grant;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] mux_data;
  logic             load;
  logic             xfer;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic [SELW-1:0]  sel_p1;

`ifdef ARB_MUX_RR_EN
  logic [SELW-1:0]  ptr_p1;

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_rr_arbiter (
    .req   (in_valid),
    .ptr   (ptr_p1),
    .grant (grant)
  );

  // Pointer moves just past the winner, only when a word is actually taken
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_p1 <= SELW'(ARB_PTR_RST);
    end else if (xfer) begin
      ptr_p1 <= (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`else
  // Fixed priority: isolate the lowest set request bit
  assign grant = in_valid & (~in_valid + N'(1));
`endif

  assign grant_idx = SELW'(onehot_to_idx(ARB_MAX_N'(grant)));

  // The stage can take a new word when empty or when its current word leaves this cycle.
  // Reset suppresses every in_ready so nothing is accepted while state is being cleared.
  assign load     = !vld_p1 || out_ready;
  assign in_ready = rst ? '0 : (grant & {N{load}});
  assign xfer     = |in_ready;

  // AND-OR data select over the one-hot grant
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N; i++) begin
      mux_data = mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  // ---- stage p1: output register ----
  // Capture on transfer; on drain without refill only valid drops, data and sel hold
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      sel_p1  <= '0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= mux_data;
      sel_p1  <= grant_idx;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_sel   = sel_p1;

endmodule

// File: tb/tb_arb_mux_n.sv
// Self-checking bench for arb_mux_n (N=4, WIDTH=32) against a behavioural model.
// Expectations follow ARB_MUX_RR_EN the same way the design does.
module tb_arb_mux_n;

  localparam int N = 4;
  localparam int W = 32;
  localparam int SW = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic         m_vld;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_ptr;

  arb_mux_n #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Index of the channel that should be accepted this cycle, -1 if none
  function automatic int model_winner();
    if (rst || in_valid == '0 || (m_vld && !out_ready)) return -1;
`ifdef ARB_MUX_RR_EN
    for (int k = 0; k < N; k++) begin
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
`else
    for (int k = 0; k < N; k++) begin
      if (in_valid[k]) return k;
    end
`endif
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int w;
    w = model_winner();
    if (w < 0) return '0;
    return N'(1) << w;
  endfunction

  // Advance one clock and the model alongside it; inputs change 1 time unit after the edge
  task automatic cycle();
    int w;
    w = model_winner();
    @(posedge clk);
    if (rst) begin
      m_vld = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
    end else if (w >= 0) begin
      m_vld  = 1'b1;
      m_data = in_data[w*W +: W];
      m_sel  = w;
      m_ptr  = (w + 1) % N;
    end else if (out_ready) begin
      m_vld = 1'b0;
    end
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1; rand_data();
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        errors++; $display("FAIL reset_in_ready: got %b want 0000", in_ready);
      end
      cycle();
      checks++;
      if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_out: got valid=%b sel=%0d data=%h want 0/0/0", out_valid, out_sel, out_data);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++; $display("FAIL reset_first_grant: got %b want 0001", in_ready);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== in_data[0 +: W]) begin
      errors++;
      $display("FAIL reset_first_word: got valid=%b sel=%0d data=%h want 1/0/%h", out_valid, out_sel, out_data, in_data[0 +: W]);
    end
  endtask

  task automatic test_single();
    in_valid = 4'b0100; rand_data(); in_data[2*W +: W] = 32'hDEAD_BEEF; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      errors++; $display("FAIL single_in_ready: got %b want 0100", in_ready);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || out_sel !== 2'd2) begin
      errors++;
      $display("FAIL single_out: got valid=%b data=%h sel=%0d want 1/deadbeef/2", out_valid, out_data, out_sel);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    held = out_data;
    in_valid = 4'b1010; rand_data(); out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        errors++; $display("FAIL stall_in_ready: got %b want 0000", in_ready);
      end
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== held || out_sel !== 2'd2) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b data=%h sel=%0d want 1/%h/2", out_valid, out_data, out_sel, held);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rand_data();
      #1;
      checks++;
      if (in_ready !== exp_ready() || in_ready == 4'b0000) begin
        errors++; $display("FAIL release_in_ready: got %b want %b", in_ready, exp_ready());
      end
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== m_data || out_sel !== SW'(m_sel)) begin
        errors++;
        $display("FAIL release_beat: got valid=%b data=%h sel=%0d want 1/%h/%0d", out_valid, out_data, out_sel, m_data, m_sel);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp_seq [5];
`ifdef ARB_MUX_RR_EN
    exp_seq = '{0, 1, 2, 3, 0};
`else
    exp_seq = '{0, 0, 0, 0, 0};
`endif
    rst = 1'b1; cycle(); rst = 1'b0;
    in_valid = 4'hF; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      rand_data();
      #1;
      checks++;
      if (in_ready !== (N'(1) << exp_seq[c])) begin
        errors++; $display("FAIL rr_in_ready[%0d]: got %b want %b", c, in_ready, N'(1) << exp_seq[c]);
      end
      cycle();
      checks++;
      if (out_sel !== SW'(exp_seq[c]) || out_data !== m_data || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_sel[%0d]: got sel=%0d data=%h want %0d/%h", c, out_sel, out_data, exp_seq[c], m_data);
      end
    end
  endtask

  task automatic test_wrap_sparse();
    int exp_seq [3];
`ifdef ARB_MUX_RR_EN
    exp_seq = '{0, 1, 0};
`else
    exp_seq = '{0, 0, 0};
`endif
    rst = 1'b1; cycle(); rst = 1'b0;
    out_ready = 1'b1; in_valid = 4'b0100; rand_data();
    cycle();
    in_valid = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      rand_data();
      #1;
      checks++;
      if (in_ready !== (N'(1) << exp_seq[c])) begin
        errors++; $display("FAIL wrap_in_ready[%0d]: got %b want %b", c, in_ready, N'(1) << exp_seq[c]);
      end
      cycle();
      checks++;
      if (out_sel !== SW'(exp_seq[c]) || out_data !== in_data[exp_seq[c]*W +: W]) begin
        errors++;
        $display("FAIL wrap_sel[%0d]: got sel=%0d data=%h want %0d/%h", c, out_sel, out_data, exp_seq[c], in_data[exp_seq[c]*W +: W]);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b1; in_valid = 4'b0100; rand_data();
    cycle();
    in_valid = 4'hF; out_ready = 1'b0;
    cycle();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL midstall_setup: got valid=%b want 1", out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      errors++; $display("FAIL midstall_rst_ready: got %b want 0000", in_ready);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 2'd0) begin
      errors++;
      $display("FAIL midstall_drop: got valid=%b data=%h sel=%0d want 0/0/0", out_valid, out_data, out_sel);
    end
    rst = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      errors++; $display("FAIL midstall_ptr: got %b want 0001", in_ready);
    end
    cycle();
    checks++;
    if (out_sel !== 2'd0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL midstall_first: got sel=%0d valid=%b want 0/1", out_sel, out_valid);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 39) == 0);
      in_valid  = ($urandom_range(0, 5) == 0) ? 4'b0000 : N'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      rand_data();
      #1;
      checks++;
      if (in_ready !== exp_ready()) begin
        errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b", c, in_ready, exp_ready());
      end
      cycle();
      checks++;
      if (out_valid !== m_vld || out_data !== m_data || out_sel !== SW'(m_sel)) begin
        errors++;
        $display("FAIL rand_out[%0d]: got valid=%b data=%h sel=%0d want %b/%h/%0d", c, out_valid, out_data, out_sel, m_vld, m_data, m_sel);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
    m_vld = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_round_robin();
    test_wrap_sparse();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
